microsequencer: RTL and testbench

Next-state sequencer for the microprogrammed control unit. Each cycle it takes the next-state fields latched by the control register (N, inv, select, cr) and the datapath/memory status flags, and chooses the next 10-bit control-store address. The result is held in a state register that addresses the control ROM, so the ROM output is latched into the control register on the following edge. It also owns a small micro-return stack so common microcode sequences can be shared as micro-subroutines.

---
 rtl/control_unit_pkg.sv | 17 +
 rtl/micro_return_stack.sv | 31 +++
 rtl/microsequencer.sv | 76 +++++++
 tb/tb_microsequencer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// control_unit_pkg: shared next-state mode encodings, condition indices and default addresses.
package control_unit_pkg;
  typedef enum logic [2:0] {
    NS_DECODE  = 3'd0,
    NS_FETCH   = 3'd1,
    NS_CBRANCH = 3'd2,
    NS_INCR    = 3'd3,
    NS_JUMP    = 3'd4,
    NS_CWAIT   = 3'd5,
    NS_CALL    = 3'd6,
    NS_RET     = 3'd7
  } ns_mode_e;
  localparam int COND_MOC = 0;
  localparam int COND_TEST = 1;
  localparam logic [9:0] FETCH_STATE_DEF = 10'd1;
  localparam logic [9:0] RESET_STATE_DEF = 10'd0;
endpackage

// File: rtl/micro_return_stack.sv
// micro_return_stack: LIFO of return addresses; reset clears only the pointer.
module micro_return_stack #(
  parameter int W = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] sp;
  logic [AW:0] sp_m1;
  assign sp_m1 = sp - 1'b1;
  assign full = sp == (AW+1)'(DEPTH);
  assign empty = sp == '0;
  assign dout = mem[sp_m1[AW-1:0]];
  always_ff @(posedge clk) begin
    if (reset) sp <= '0;
    else if (push && !full) sp <= sp + 1'b1;
    else if (pop && !empty) sp <= sp_m1;
  end
  always_ff @(posedge clk) begin
    if (!reset && push && !full) mem[sp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/microsequencer.sv
// microsequencer: picks the next control-store address from N, the selected condition and the return stack.
module microsequencer
  import control_unit_pkg::*;
#(
  parameter int STATE_W = 10,
  parameter int STACK_DEPTH = 4,
  parameter logic [STATE_W-1:0] FETCH_STATE = FETCH_STATE_DEF,
  parameter logic [STATE_W-1:0] RESET_STATE = RESET_STATE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         N,
  input  logic               inv,
  input  logic [1:0]         select,
  input  logic [STATE_W-1:0] cr,
  input  logic [3:0]         cond_in,
  input  logic [STATE_W-1:0] decode_state,
  input  logic               hold,
  output logic [STATE_W-1:0] state,
  output logic               stack_err
);
  logic c;
  logic [STATE_W-1:0] incr;
  logic [STATE_W-1:0] nxt;
  logic [STATE_W-1:0] ret_addr;
  logic err_nxt;
  logic push;
  logic pop;
  logic full;
  logic empty;
  assign c = cond_in[select] ^ inv;
  assign incr = state + STATE_W'(1);
  micro_return_stack #(.W(STATE_W), .DEPTH(STACK_DEPTH)) u_stack (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(incr),
    .dout(ret_addr),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    nxt = state;
    err_nxt = stack_err;
    push = 1'b0;
    pop = 1'b0;
    case (ns_mode_e'(N))
      NS_DECODE:  nxt = decode_state;
      NS_FETCH:   nxt = FETCH_STATE;
      NS_CBRANCH: nxt = c ? cr : incr;
      NS_INCR:    nxt = incr;
      NS_JUMP:    nxt = cr;
      NS_CWAIT:   nxt = c ? cr : state;
      NS_CALL: begin
        nxt = cr;
        push = !hold;
        err_nxt = stack_err | full;
      end
      NS_RET: begin
        nxt = empty ? FETCH_STATE : ret_addr;
        pop = !hold;
        err_nxt = stack_err | empty;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RESET_STATE;
      stack_err <= 1'b0;
    end else if (!hold) begin
      state <= nxt;
      stack_err <= err_nxt;
    end
  end
endmodule

// File: tb/tb_microsequencer.sv
// tb_microsequencer: directed vector table, hand sequences and randomized run against a queue-based model.
module tb_microsequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] N = 3'd3;
  logic       inv = 1'b0;
  logic [1:0] select = 2'd0;
  logic [9:0] cr = '0;
  logic [3:0] cond_in = '0;
  logic [9:0] decode_state = '0;
  logic       hold = 1'b0;
  logic [9:0] state;
  logic       stack_err;
  int checks = 0;
  int errors = 0;
  int ms = 0;
  int stk[$];
  bit merr = 1'b0;

  microsequencer dut (
    .clk(clk), .reset(reset), .N(N), .inv(inv), .select(select), .cr(cr),
    .cond_in(cond_in), .decode_state(decode_state), .hold(hold),
    .state(state), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst;
    bit       hld;
    int       n;
    bit       iv;
    int       sel;
    int       tgt;
    int       cnd;
    int       dec;
    int       exp_state;
    bit       exp_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit h, int n, bit iv, int sel, int tgt, int cnd, int dec, int es, bit ee);
    vec_t v;
    v.rst = r; v.hld = h; v.n = n; v.iv = iv; v.sel = sel; v.tgt = tgt;
    v.cnd = cnd; v.dec = dec; v.exp_state = es; v.exp_err = ee;
    return v;
  endfunction

  // Reference behaviour: addresses are plain integers modulo 1024, the stack is a queue.
  task automatic model_step(bit r, bit h, int n, bit iv, int sel, int tgt, int cnd, int dec);
    bit c;
    c = ((cnd >> sel) & 1) != (iv ? 1 : 0);
    if (r) begin
      ms = 0; stk.delete(); merr = 1'b0;
    end else if (!h) begin
      if (n == 0) ms = dec;
      else if (n == 1) ms = 1;
      else if (n == 2) ms = c ? tgt : (ms + 1) % 1024;
      else if (n == 3) ms = (ms + 1) % 1024;
      else if (n == 4) ms = tgt;
      else if (n == 5) ms = c ? tgt : ms;
      else if (n == 6) begin
        if (stk.size() < 4) stk.push_back((ms + 1) % 1024);
        else merr = 1'b1;
        ms = tgt;
      end else begin
        if (stk.size() > 0) ms = stk.pop_back();
        else begin ms = 1; merr = 1'b1; end
      end
    end
  endtask

  task automatic apply(bit r, bit h, int n, bit iv, int sel, int tgt, int cnd, int dec);
    reset = r; hold = h; N = 3'(n); inv = iv; select = 2'(sel);
    cr = 10'(tgt); cond_in = 4'(cnd); decode_state = 10'(dec);
    model_step(r, h, n, iv, sel, tgt, cnd, dec);
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, int exp_s, bit exp_e);
    checks++;
    if (int'(state) != exp_s || stack_err != exp_e) begin
      errors++;
      $display("FAIL %s: state=%0d err=%0b, required state=%0d err=%0b", name, state, stack_err, exp_s, exp_e);
    end
  endtask

  initial begin
    tbl.push_back(mk(1,0,3,0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,0,3,0,0,0,0,0, 1,0));
    tbl.push_back(mk(0,0,3,0,0,0,0,0, 2,0));
    tbl.push_back(mk(0,0,3,0,0,0,0,0, 3,0));
    tbl.push_back(mk(0,0,4,0,0,40,0,0, 40,0));
    tbl.push_back(mk(0,0,5,1,0,41,1,0, 40,0));
    tbl.push_back(mk(0,0,5,1,0,41,0,0, 41,0));
    tbl.push_back(mk(0,0,4,0,0,50,0,0, 50,0));
    tbl.push_back(mk(0,0,2,0,1,200,2,0, 200,0));
    tbl.push_back(mk(0,0,4,0,0,50,0,0, 50,0));
    tbl.push_back(mk(0,0,2,0,1,200,0,0, 51,0));
    tbl.push_back(mk(0,0,4,0,0,30,0,0, 30,0));
    tbl.push_back(mk(0,0,6,0,0,300,0,0, 300,0));
    tbl.push_back(mk(0,0,7,0,0,0,0,0, 31,0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0,0,6,0,0,100+i,0,0, 100+i,0));
    tbl.push_back(mk(0,0,6,0,0,104,0,0, 104,1));
    tbl.push_back(mk(0,0,7,0,0,0,0,0, 103,1));
    tbl.push_back(mk(0,0,7,0,0,0,0,0, 102,1));
    tbl.push_back(mk(0,0,7,0,0,0,0,0, 101,1));
    tbl.push_back(mk(0,0,7,0,0,0,0,0, 32,1));
    tbl.push_back(mk(0,0,7,0,0,0,0,0, 1,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,77, 77,1));
    tbl.push_back(mk(0,0,1,0,0,0,0,0, 1,1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,1,4,0,0,500,0,0, 1,1));
    tbl.push_back(mk(1,1,4,0,0,500,0,0, 0,0));
    tbl.push_back(mk(0,0,4,0,0,500,0,0, 500,0));
    tbl.push_back(mk(0,0,4,0,0,1023,0,0, 1023,0));
    tbl.push_back(mk(0,0,3,0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,0,5,0,3,9,8,0, 9,0));
    tbl.push_back(mk(0,0,2,1,2,7,4,0, 10,0));

    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].hld, tbl[i].n, tbl[i].iv, tbl[i].sel, tbl[i].tgt, tbl[i].cnd, tbl[i].dec);
      check($sformatf("vec%0d", i), tbl[i].exp_state, tbl[i].exp_err);
    end

    // Back-to-back CALL/RET, then reset with a non-empty stack must discard it.
    apply(1,0,3,0,0,0,0,0);
    apply(0,0,4,0,0,600,0,0);
    apply(0,0,6,0,0,700,0,0);
    check("call_to_700", 700, 0);
    apply(0,0,6,0,0,800,0,0);
    apply(0,0,7,0,0,0,0,0);
    check("ret_to_701", 701, 0);
    apply(0,0,6,0,0,900,0,0);
    apply(1,0,7,0,0,0,0,0);
    check("reset_mid_stack", 0, 0);
    apply(0,0,7,0,0,0,0,0);
    check("ret_after_reset", 1, 1);
    apply(0,0,5,0,0,55,0,0);
    apply(1,0,5,0,0,55,0,0);
    check("reset_in_cwait", 0, 0);

    for (int i = 0; i < 2000; i++) begin
      apply($urandom_range(0, 40) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7),
            1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 1023),
            $urandom_range(0, 15), $urandom_range(0, 1023));
      check("random", ms, merr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
